sample_link_scheduler: RTL and testbench
========================================

// Module: sample_link_scheduler
// PURPOSE
//  Buffers processed ADC samples and schedules them onto the UART and nRF24L01+ sinks.
//  Sits between the acquisition FSM's proc_data_valid stream and the two link transmitters.
//  mode selects the destination set; in broadcast mode each sample is delivered to both
//  sinks before it retires. Groups wireless samples into bursts and counts dropped samples.
// PARAMETERS
//  DATA_W      12   sample width in bits
//  FIFO_DEPTH  8    sample FIFO entries; must be a power of 2, >=2
//  NRF_BURST   16   samples per wireless payload burst; >=1
// PORTS
//  clk_100MHz    in   1                      system clock
//  reset_n       in   1                      asynchronous, active-low reset
//  mode          in   2                      00=none, 01=UART, 10=wireless, 11=both
//  in_valid      in   1                      one-cycle strobe: in_data is a new sample
//  in_data       in   DATA_W                 processed sample
//  uart_valid    out  1                      sample offered to UART
//  uart_data     out  DATA_W                 UART sample
//  uart_ready    in   1                      UART accepts when uart_valid&uart_ready
//  nrf_valid     out  1                      sample offered to wireless
//  nrf_data      out  DATA_W                 wireless sample
//  nrf_first     out  1                      qualifies nrf_valid: first sample of a burst
//  nrf_ready     in   1                      wireless accepts when nrf_valid&nrf_ready
//  fifo_level    out  $clog2(FIFO_DEPTH)+1   occupied entries, 0..FIFO_DEPTH
//  overflow_cnt  out  16                     dropped-sample count, saturating
//  busy          out  1                      FIFO non-empty or state==SEND
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty, state IDLE, burst count 0, pend_u=pend_n=0.
//  All outputs are registered or decoded from registers. No input-to-output combinational path.
//  Write side:
//   - in_valid & mode!=00 & !full: push, level+1.
//   - in_valid & mode!=00 & full: drop, overflow_cnt+1, saturating at 16'hFFFF.
//   - A pop in the same cycle does not free space for that cycle's push.
//   - in_valid & mode==00: sample discarded, not counted.
//  Read side: FSM with states IDLE and SEND. Holding register hold plus pend_u/pend_n flags.
//   - Load condition: !empty & mode!=00. On load: hold<=head, pop, pend_u<=mode[0],
//     pend_n<=mode[1], mode_lat<=mode, next state SEND.
//   - IDLE: on load condition -> SEND; otherwise stay.
//   - SEND: uart_valid=pend_u, nrf_valid=pend_n, uart_data=nrf_data=hold.
//     hold stays stable while either valid is high.
//   - A handshake on a sink clears that sink's pend flag next cycle.
//   - Sample retires when no pend flag remains after this cycle's handshakes.
//     On retire: if load condition holds, load back-to-back and stay in SEND; else IDLE.
//   - Throughput 1 sample/clk when all enabled sinks hold ready high.
//   - mode changes mid-SEND apply only to the next load. A mode==00 change leaves the current
//     sample pending until delivered, and FIFO contents stay held.
//  Latency: in_valid at cycle N (empty FIFO, IDLE) -> valid asserted at N+2.
//  Burst counter bcnt, 0..NRF_BURST-1:
//   - nrf_first = nrf_valid & (bcnt==0).
//   - Each nrf handshake increments bcnt, wrapping NRF_BURST-1 -> 0.
//   - A load with mode[1]==0 clears bcnt, so a new wireless session starts a fresh burst.
//  Simultaneous push and pop on a non-full FIFO: level unchanged, pointers wrap mod FIFO_DEPTH.
//  reset_n asserted mid-SEND: held sample and FIFO contents discarded; valids drop asynchronously.
// TESTING
//  T1: mode=01, uart_ready=1, 3 samples 0x001..0x003
//      -> uart_data 0x001,0x002,0x003 on consecutive cycles, first at N+2; nrf_valid stays 0.
//  T2: mode=11, uart_ready=1, nrf_ready held 0 for 5 cycles then 1, sample 0xABC
//      -> UART takes 0xABC once; nrf_valid high 6 cycles with 0xABC; then retires.
//  T3: mode=01, uart_ready=0, 12 strobes at FIFO_DEPTH=8
//      -> fifo_level=8, overflow_cnt=3 (1 sample in hold); on ready=1 the 9 kept samples arrive in order.
//  T4: mode=10, nrf_ready=1, 33 samples at NRF_BURST=16
//      -> nrf_first on samples 0, 16 and 32 only.
//  T5: mode=01 with 4 samples queued, uart_ready=0, switch to mode=10
//      -> held sample still goes to UART; remaining 3 go to nrf only, nrf_first on the first.
//  T6: reset_n pulsed low while SEND with FIFO level 5
//      -> all outputs 0 immediately; fifo_level=0 and overflow_cnt=0 after release.

Source files
------------

// File: rtl/sample_link_scheduler.sv
// sample_link_scheduler
// Buffers processed ADC samples in a small FIFO and delivers each one to the
// UART sink, the wireless sink, or both, depending on mode. In broadcast mode a
// sample retires only after both sinks have taken it. Wireless samples are
// grouped into bursts of NRF_BURST, and samples that arrive while the FIFO is
// full are counted.
module sample_link_scheduler #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int NRF_BURST  = 16
) (
  input  logic                          clk_100MHz,
  input  logic                          reset_n,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          uart_valid,
  output logic [DATA_W-1:0]             uart_data,
  input  logic                          uart_ready,
  output logic                          nrf_valid,
  output logic [DATA_W-1:0]             nrf_data,
  output logic                          nrf_first,
  input  logic                          nrf_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt,
  output logic                          busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BCNT_W = (NRF_BURST > 1) ? $clog2(NRF_BURST) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Registered state
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [15:0]       ovf_q, ovf_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              pend_u_q, pend_u_d;
  logic              pend_n_q, pend_n_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;

  // Combinational helpers
  logic fifo_empty_s;
  logic fifo_full_s;
  logic mode_on_s;
  logic push_s;
  logic drop_s;
  logic pop_s;
  logic hs_u_s;
  logic hs_n_s;
  logic load_ok_s;

  // Write-side qualification and sink handshakes, all from current-cycle state
  always_comb begin
    fifo_empty_s = (level_q == {LVL_W{1'b0}});
    fifo_full_s  = (level_q == LVL_W'(FIFO_DEPTH));
    mode_on_s    = (mode != 2'b00);
    // Fullness is judged before any pop, so a same-cycle pop never makes room.
    push_s       = in_valid & mode_on_s & ~fifo_full_s;
    drop_s       = in_valid & mode_on_s & fifo_full_s;
    hs_u_s       = pend_u_q & uart_ready;
    hs_n_s       = pend_n_q & nrf_ready;
    load_ok_s    = ~fifo_empty_s & mode_on_s;
  end

  // Read FSM: load head into hold, deliver to pending sinks, retire when none remain
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    pend_u_d = pend_u_q & ~hs_u_s;
    pend_n_d = pend_n_q & ~hs_n_s;
    pop_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_ok_s) begin
          hold_d   = mem_q[rd_ptr_q];
          pop_s    = 1'b1;
          pend_u_d = mode[0];
          pend_n_d = mode[1];
          state_d  = ST_SEND;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!pend_u_d && !pend_n_d) begin
          // Sample retires this cycle; chain the next one without a bubble.
          if (load_ok_s) begin
            hold_d   = mem_q[rd_ptr_q];
            pop_s    = 1'b1;
            pend_u_d = mode[0];
            pend_n_d = mode[1];
            state_d  = ST_SEND;
          end else begin
            state_d  = ST_IDLE;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        pend_u_d = 1'b0;
        pend_n_d = 1'b0;
      end
    endcase
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (drop_s && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Burst position: a non-wireless load restarts the burst, otherwise count handshakes
  always_comb begin
    if (pop_s && !mode[1]) begin
      bcnt_d = {BCNT_W{1'b0}};
    end else if (hs_n_s) begin
      if (bcnt_q == BCNT_W'(NRF_BURST - 1)) begin
        bcnt_d = {BCNT_W{1'b0}};
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // Sample storage; contents are meaningless until pointers say otherwise, so no reset
  always_ff @(posedge clk_100MHz) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      ovf_q    <= 16'h0000;
      state_q  <= ST_IDLE;
      hold_q   <= {DATA_W{1'b0}};
      pend_u_q <= 1'b0;
      pend_n_q <= 1'b0;
      bcnt_q   <= {BCNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      pend_u_q <= pend_u_d;
      pend_n_q <= pend_n_d;
      bcnt_q   <= bcnt_d;
    end
  end

  // Outputs decoded purely from registers
  assign uart_valid   = (state_q == ST_SEND) & pend_u_q;
  assign nrf_valid    = (state_q == ST_SEND) & pend_n_q;
  assign nrf_first    = nrf_valid & (bcnt_q == {BCNT_W{1'b0}});
  assign uart_data    = hold_q;
  assign nrf_data     = hold_q;
  assign fifo_level   = level_q;
  assign overflow_cnt = ovf_q;
  assign busy         = ~fifo_empty_s | (state_q == ST_SEND);

endmodule

// File: tb/tb_sample_link_scheduler.sv
// Testbench for sample_link_scheduler: queue-based reference model compared every
// cycle, plus directed scenarios whose delivered sequences are checked against literals.
module tb_sample_link_scheduler;

  localparam int DATA_W     = 12;
  localparam int FIFO_DEPTH = 8;
  localparam int NRF_BURST  = 16;

  logic              clk_100MHz = 1'b0;
  logic              reset_n    = 1'b0;
  logic [1:0]        mode       = 2'b00;
  logic              in_valid   = 1'b0;
  logic [DATA_W-1:0] in_data    = '0;
  logic              uart_ready = 1'b0;
  logic              nrf_ready  = 1'b0;
  logic              uart_valid;
  logic [DATA_W-1:0] uart_data;
  logic              nrf_valid;
  logic [DATA_W-1:0] nrf_data;
  logic              nrf_first;
  logic [3:0]        fifo_level;
  logic [15:0]       overflow_cnt;
  logic              busy;

  sample_link_scheduler #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .NRF_BURST(NRF_BURST)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .mode(mode),
    .in_valid(in_valid), .in_data(in_data),
    .uart_valid(uart_valid), .uart_data(uart_data), .uart_ready(uart_ready),
    .nrf_valid(nrf_valid), .nrf_data(nrf_data), .nrf_first(nrf_first),
    .nrf_ready(nrf_ready), .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt), .busy(busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 'h%0h required 'h%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 ns after a rising edge and are consumed at the next one.
  task automatic cyc;
    @(posedge clk_100MHz);
    #2;
  endtask

  // Reference model: FIFO as a queue, one sample in flight with per-sink "still owed" flags.
  logic [DATA_W-1:0] m_fifo[$];
  logic [DATA_W-1:0] m_hold = '0;
  bit                m_pu = 1'b0;
  bit                m_pn = 1'b0;
  int                m_bcnt = 0;
  int                m_ovf = 0;

  initial begin
    forever begin
      @(posedge clk_100MHz or negedge reset_n);
      if (!reset_n) begin
        m_fifo.delete();
        m_hold = '0;
        m_pu = 1'b0;
        m_pn = 1'b0;
        m_bcnt = 0;
        m_ovf = 0;
      end else begin
        bit owe_u, owe_n, was_full, was_empty;
        was_full  = (m_fifo.size() == FIFO_DEPTH);
        was_empty = (m_fifo.size() == 0);
        owe_u = m_pu && !uart_ready;
        owe_n = m_pn && !nrf_ready;
        if (m_pn && nrf_ready) m_bcnt = (m_bcnt + 1) % NRF_BURST;
        if (!owe_u && !owe_n && !was_empty && mode != 2'b00) begin
          m_hold = m_fifo.pop_front();
          owe_u = mode[0];
          owe_n = mode[1];
          if (!mode[1]) m_bcnt = 0;
        end
        if (in_valid && mode != 2'b00) begin
          if (!was_full) m_fifo.push_back(in_data);
          else if (m_ovf < 65535) m_ovf++;
        end
        m_pu = owe_u;
        m_pn = owe_n;
      end
    end
  end

  // Delivered-sample logs for the directed checks
  logic [DATA_W-1:0] ulog[$];
  logic [DATA_W-1:0] nlog[$];
  bit                flog[$];
  int                nv_cnt = 0;

  // Per-cycle comparison against the model, mid-cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk_100MHz);
      if (reset_n) begin
        chk("uart_valid", 32'(uart_valid), 32'(m_pu));
        chk("nrf_valid", 32'(nrf_valid), 32'(m_pn));
        chk("nrf_first", 32'(nrf_first), 32'(m_pn && m_bcnt == 0));
        if (m_pu) chk("uart_data", 32'(uart_data), 32'(m_hold));
        if (m_pn) chk("nrf_data", 32'(nrf_data), 32'(m_hold));
        chk("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
        chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
        chk("busy", 32'(busy), 32'((m_fifo.size() != 0) || m_pu || m_pn));
        if (uart_valid && uart_ready) ulog.push_back(uart_data);
        if (nrf_valid && nrf_ready) begin
          nlog.push_back(nrf_data);
          flog.push_back(nrf_first);
        end
        if (nrf_valid) nv_cnt++;
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_100MHz);
    #2;
    chk("rst_valids", 32'({uart_valid, nrf_valid, nrf_first, busy}), 32'd0);
    chk("rst_level_ovf", 32'({fifo_level, overflow_cnt}), 32'd0);
    chk("rst_data", 32'({uart_data, nrf_data}), 32'd0);
    reset_n = 1'b1;
    cyc;

    // T1: UART only, three samples, two-cycle latency then one per clock
    mode = 2'b01; uart_ready = 1'b1;
    in_valid = 1'b1; in_data = 12'h001; cyc;
    chk("t1_lat_n1", 32'(uart_valid), 32'd0);
    in_data = 12'h002; cyc;
    chk("t1_first_valid", 32'(uart_valid), 32'd1);
    chk("t1_d1", 32'(uart_data), 32'h001);
    in_data = 12'h003; cyc;
    chk("t1_d2", 32'(uart_data), 32'h002);
    in_valid = 1'b0; cyc;
    chk("t1_d3", 32'(uart_data), 32'h003);
    chk("t1_nrf_quiet", 32'(nrf_valid), 32'd0);
    cyc;
    chk("t1_idle", 32'(uart_valid), 32'd0);

    // T2: broadcast, wireless stalls five cycles
    ulog.delete(); nlog.delete(); flog.delete(); nv_cnt = 0;
    mode = 2'b11; uart_ready = 1'b1; nrf_ready = 1'b0;
    in_valid = 1'b1; in_data = 12'hABC; cyc;
    in_valid = 1'b0; cyc;
    repeat (5) cyc;
    nrf_ready = 1'b1; cyc;
    nrf_ready = 1'b0; repeat (2) cyc;
    chk("t2_uart_cnt", 32'(ulog.size()), 32'd1);
    chk("t2_uart_data", 32'(ulog[0]), 32'hABC);
    chk("t2_nrf_cnt", 32'(nlog.size()), 32'd1);
    chk("t2_nrf_data", 32'(nlog[0]), 32'hABC);
    chk("t2_nrf_valid_cycles", 32'(nv_cnt), 32'd6);
    chk("t2_retired", 32'(busy), 32'd0);

    // T3: overflow with the UART stalled
    ulog.delete();
    mode = 2'b01; uart_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = 12'h100 + 12'(i); cyc;
    end
    in_valid = 1'b0; cyc;
    chk("t3_level", 32'(fifo_level), 32'd8);
    chk("t3_ovf", 32'(overflow_cnt), 32'd3);
    uart_ready = 1'b1; repeat (12) cyc;
    uart_ready = 1'b0;
    chk("t3_count", 32'(ulog.size()), 32'd9);
    for (int i = 0; i < 9; i++) chk("t3_order", 32'(ulog[i]), 32'h100 + 32'(i));

    // T4: wireless bursts
    nlog.delete(); flog.delete();
    mode = 2'b10; nrf_ready = 1'b1;
    for (int i = 0; i < 33; i++) begin
      in_valid = 1'b1; in_data = 12'h300 + 12'(i); cyc;
    end
    in_valid = 1'b0; repeat (4) cyc;
    chk("t4_count", 32'(nlog.size()), 32'd33);
    for (int i = 0; i < 33; i++) begin
      chk("t4_first", 32'(flog[i]), 32'((i % 16) == 0));
      chk("t4_data", 32'(nlog[i]), 32'h300 + 32'(i));
    end
    chk("t4_ovf_kept", 32'(overflow_cnt), 32'd3);

    // T5: mode switch while a UART sample is pending
    ulog.delete(); nlog.delete(); flog.delete();
    mode = 2'b01; uart_ready = 1'b0; nrf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 12'h200 + 12'(i); cyc;
    end
    in_valid = 1'b0; cyc;
    mode = 2'b10; nrf_ready = 1'b1; repeat (3) cyc;
    chk("t5_nrf_waits", 32'(nlog.size()), 32'd0);
    uart_ready = 1'b1; cyc;
    uart_ready = 1'b0; repeat (5) cyc;
    chk("t5_uart_cnt", 32'(ulog.size()), 32'd1);
    chk("t5_uart_data", 32'(ulog[0]), 32'h201);
    chk("t5_nrf_cnt", 32'(nlog.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t5_nrf_data", 32'(nlog[i]), 32'h202 + 32'(i));
      chk("t5_nrf_first", 32'(flog[i]), 32'(i == 0));
    end
    nrf_ready = 1'b0;

    // T7: mode 00 discards input silently and freezes the FIFO
    mode = 2'b00;
    in_valid = 1'b1; in_data = 12'h555; repeat (3) cyc;
    in_valid = 1'b0; cyc;
    chk("t7_discard_level", 32'(fifo_level), 32'd0);
    chk("t7_discard_ovf", 32'(overflow_cnt), 32'd3);
    ulog.delete();
    mode = 2'b01; uart_ready = 1'b0;
    in_valid = 1'b1; in_data = 12'h401; cyc;
    in_data = 12'h402; cyc;
    in_valid = 1'b0; cyc;
    mode = 2'b00; uart_ready = 1'b1; repeat (3) cyc;
    chk("t7_held_sent", 32'(ulog.size()), 32'd1);
    chk("t7_held_data", 32'(ulog[0]), 32'h401);
    chk("t7_fifo_frozen", 32'(fifo_level), 32'd1);
    chk("t7_busy", 32'(busy), 32'd1);
    mode = 2'b01; repeat (3) cyc;
    chk("t7_drain", 32'(ulog.size()), 32'd2);
    chk("t7_drain_data", 32'(ulog[1]), 32'h402);

    // T6: asynchronous reset while sending with five samples queued
    mode = 2'b01; uart_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 12'h600 + 12'(i); cyc;
    end
    in_valid = 1'b0; cyc;
    chk("t6_level_pre", 32'(fifo_level), 32'd5);
    chk("t6_sending", 32'(uart_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_valids", 32'({uart_valid, nrf_valid, nrf_first, busy}), 32'd0);
    chk("t6_async_level", 32'(fifo_level), 32'd0);
    chk("t6_async_ovf", 32'(overflow_cnt), 32'd0);
    cyc;
    reset_n = 1'b1; cyc;
    chk("t6_level_post", 32'(fifo_level), 32'd0);
    chk("t6_ovf_post", 32'(overflow_cnt), 32'd0);
    chk("t6_idle_post", 32'(uart_valid), 32'd0);
    repeat (2) cyc;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
